// File: rtl/hex_scan_pkg.sv
// Shared definitions for the hex display scan controller.
//   state_t  : scan FSM states (GAP = dead time, SHOW = digit lit)
//   SEG_OFF  : active-low segment pattern with every segment dark
//   lzb_mask : per-digit leading-zero blank mask for a display word
package hex_scan_pkg;

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam int         MAX_DIGITS = 8;
  localparam int         WORD_W     = 4 * MAX_DIGITS;

  // Bit k is set when nibbles digits-1..k of the word are all zero.
  // Digit 0 always shows, so bit 0 is never set.
  function automatic logic [MAX_DIGITS-1:0] lzb_mask(input logic [WORD_W-1:0] word,
                                                     input int                digits);
    logic [MAX_DIGITS-1:0] mask;
    logic                  zero_so_far;
    mask        = '0;
    zero_so_far = 1'b1;
    for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
      if (k < digits) begin
        zero_so_far = zero_so_far & (word[4*k +: 4] == 4'h0);
        mask[k]     = zero_so_far;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/hex_scan_timer.sv
// Slot timer for the scan FSM. Counts the cycles of the current slot and
// raises tc on the last one; the count restarts from zero on every slot.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   show  : 1 = SHOW slot (TICK_DIV cycles), 0 = GAP slot (GAP_CYC cycles)
//   tc    : terminal count, high during the last cycle of the slot
module hex_scan_timer #(
  parameter int TICK_DIV = 50000,
  parameter int GAP_CYC  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic show,
  output logic tc
);

  localparam int CW = $clog2((TICK_DIV > GAP_CYC) ? TICK_DIV : GAP_CYC);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tc = (cnt == (show ? SHOW_LAST : GAP_LAST));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Scan controller that time-multiplexes one external 7-segment decoder over
// DIGITS common-anode digits, with anti-ghosting dead time, frame-aligned
// display updates via a load/ack handshake, global and leading-zero blanking.
//   clk_i    : clock
//   rstn_i   : asynchronous active-low reset
//   data_i   : display word, nibble k shown on digit k
//   load_i   : one-cycle request to latch data_i as pending
//   ack_o    : one-cycle pulse when pending data becomes displayed
//   blank_i  : forces all anodes off
//   lzb_en_i : enables leading-zero blanking
//   dec_o    : nibble sent to the shared decoder
//   hex_i    : decoder result, active-low {g..a}
//   seg_o    : registered segment pins, active-low
//   an_o     : registered anode enables, active-low
module hex_scan_ctrl
  import hex_scan_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50000,
  parameter int GAP_CYC  = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic                  load_i,
  output logic                  ack_o,
  input  logic                  blank_i,
  input  logic                  lzb_en_i,
  output logic [3:0]            dec_o,
  input  logic [6:0]            hex_i,
  output logic [6:0]            seg_o,
  output logic [DIGITS-1:0]     an_o
);

  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  state_t                state;
  state_t                state_nxt;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;
  logic                  wrap;
  logic                  tc;
  logic [4*DIGITS-1:0]   disp;
  logic [4*DIGITS-1:0]   pend;
  logic                  pend_v;
  logic [MAX_DIGITS-1:0] blank_mask;

  hex_scan_timer #(
    .TICK_DIV (TICK_DIV),
    .GAP_CYC  (GAP_CYC)
  ) u_timer (
    .clk   (clk_i),
    .rst_n (rstn_i),
    .show  (state == SHOW),
    .tc    (tc)
  );

  assign dec_o      = disp[4*idx +: 4];
  assign blank_mask = lzb_mask(WORD_W'(disp), DIGITS);

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wrap      = 1'b0;
    if (tc) begin
      if (state == GAP) begin
        state_nxt = SHOW;
      end else begin
        state_nxt = GAP;
        if (idx == LAST_IDX) begin
          idx_nxt = '0;
          wrap    = 1'b1;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
    end
  end

  // ack_o is raised on the edge that enters the frame's first GAP cycle and
  // the swap into disp happens at the end of that cycle, so a load in the
  // last SHOW cycle still makes this frame and a load during the ack cycle
  // waits for the next one.
  // an_o is computed from the next state so the anodes line up with the FSM.
  // NOTE: pend is reset along with its valid flag even though it is only
  // read when pend_v is set; it is a handful of flops and keeps X out of disp.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= GAP;
      idx    <= '0;
      disp   <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
      ack_o  <= 1'b0;
      an_o   <= '1;
      seg_o  <= SEG_OFF;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      ack_o <= wrap && (pend_v || load_i);

      if (ack_o) begin
        disp <= pend;
      end

      if (load_i) begin
        pend   <= data_i;
        pend_v <= 1'b1;
      end else if (ack_o) begin
        pend_v <= 1'b0;
      end

      if (blank_i || (state_nxt == GAP)) begin
        an_o <= '1;
      end else begin
        an_o <= ~(DIGITS'(1) << idx_nxt);
      end

      if (lzb_en_i && blank_mask[idx]) begin
        seg_o <= SEG_OFF;
      end else begin
        seg_o <= hex_i;
      end
    end
  end

endmodule

// File: doc/hex_scan_ctrl.md
# hex_scan_ctrl

Scan controller for the shared 7-segment hex decoder on the lab board. It time-multiplexes one decoder across `DIGITS` common-anode digits. The block latches a display word through a load/ack handshake that only takes effect at frame boundaries, so no digit ever tears. It also inserts anti-ghosting dead time between digits and provides global blanking and leading-zero blanking. It sits between the user datapath (the source of `data_i`) and the board pins, with the decoder in its `dec_o` → `hex_i` loop.

## Interface
- `DIGITS`, default 4: number of multiplexed digits, range 2..8.
- `TICK_DIV`, default 50000: clock cycles per digit SHOW slot, minimum 2.
- `GAP_CYC`, default 16: clock cycles per dead-time GAP slot, minimum 2.
- `clk_i` in 1: single clock; all logic is on its rising edge.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `data_i` in 4*DIGITS: display word; nibble k is shown on digit k, digit 0 is least significant.
- `load_i` in 1: single-cycle request to latch `data_i` as pending.
- `ack_o` out 1: one-cycle pulse when pending data becomes the displayed data.
- `blank_i` in 1: level input; forces all anodes off.
- `lzb_en_i` in 1: level input; enables leading-zero blanking.
- `dec_o` out 4: nibble fed to the shared decoder.
- `hex_i` in 7: decoder result, active-low segments {g..a}.
- `seg_o` out 7: registered segment pins, active-low.
- `an_o` out DIGITS: registered anode enables, active-low.

## Operation
- Internal registers:
  - `disp`: displayed word.
  - `pend` and `pend_v`: pending word and its valid flag.
  - `idx`: digit index.
  - `cnt`: slot counter.
- FSM has two states, GAP and SHOW.
- GAP lasts `GAP_CYC` cycles:
  - `an_o` is all ones.
  - `dec_o` = `disp` nibble `idx`.
  - `seg_o` <= `hex_i` every cycle.
  - After `GAP_CYC` cycles, go to SHOW.
- SHOW lasts `TICK_DIV` cycles:
  - `an_o[idx]` = 0 and all other anodes are 1.
  - `seg_o` continues to track `hex_i`.
  - After `TICK_DIV` cycles, go to GAP and set `idx` <= `idx`+1, wrapping from `DIGITS`-1 to 0.
- Frame boundary is the GAP→SHOW→GAP transition where `idx` wraps to 0. On the first cycle of that GAP:
  - If `pend_v`: `disp` <= `pend`, `pend_v` <= 0, `ack_o` = 1 for one cycle.
  - The `dec_o` nibble for digit 0 is taken from the new `disp` in the following cycle, which is still inside GAP.
- Load handshake:
  - `load_i` = 1 sets `pend` <= `data_i` and `pend_v` <= 1.
  - Repeated loads before the boundary overwrite `pend`. Latest wins; only one `ack_o` is issued.
  - A `load_i` in the same cycle as the boundary apply goes into `pend` with `pend_v` = 1 and is applied at the next frame. The old `pend` is what is applied now.
- Leading-zero blanking: when `lzb_en_i` = 1, digit k (k≥1) shows `seg_o` = 7'h7F if `disp` nibbles `DIGITS`-1..k are all zero. Digit 0 is never blanked.
- `blank_i` = 1 forces `an_o` all ones in both states. Scanning, counters and the handshake continue unchanged.

## Timing
- Reset values:
  - `an_o` all ones, `seg_o` = 7'h7F, `dec_o` = 0, `ack_o` = 0.
  - `disp` = 0, `pend_v` = 0, `idx` = 0, `cnt` = 0.
  - State is GAP.
- Reset asserted mid-frame returns every register to these values immediately and discards pending data without an ack.
- `seg_o` lags `dec_o` by one cycle. Because `GAP_CYC` ≥ 2, segments are stable before the anode turns on.
- Frame period = `DIGITS`*(`GAP_CYC`+`TICK_DIV`) cycles.
- Load-to-ack latency is at most one frame period plus one cycle.
- Outputs `an_o`, `seg_o` and `ack_o` are registered, with no combinational path from inputs.
- `cnt` width is clog2(max(`TICK_DIV`, `GAP_CYC`)). `cnt` resets to 0 on every state change.

## Structure
- Package `hex_scan_pkg`:
  - State enum {GAP, SHOW}.
  - `SEG_OFF` = 7'h7F.
  - Function returning the leading-zero blank mask for a word.
- Sub-module `hex_scan_timer`: slot counter with a terminal-count pulse and a load of `GAP_CYC` or `TICK_DIV`.
- The decoder itself stays outside this block and is instantiated by the parent.

## Test plan
Bench parameters: `DIGITS`=4, `TICK_DIV`=8, `GAP_CYC`=2, frame = 40 cycles. A reference decoder model is on the `dec_o`/`hex_i` loop.
- Reset release, then run two frames → `an_o` cycles 1110/1101/1011/0111 with 2-cycle 1111 gaps between digits; `seg_o` = 7'h40 on every digit.
- Pulse `load_i` with 16'h12AF mid-frame → `ack_o` pulses exactly at the next frame's first GAP cycle; digits 0..3 then show 7'h0E, 7'h08, 7'h24, 7'h79.
- Load 16'h1111 then 16'h2222 in the same frame → a single `ack_o`, and 16'h2222 is displayed.
- Load 16'h0050 with `lzb_en_i`=1 → digits 3 and 2 show 7'h7F, digit 1 shows 7'h12, digit 0 shows 7'h40. Load 16'h0000 → only digit 0 is lit.
- Hold `blank_i`=1 for one frame while loading 16'hBEEF → `an_o` stays all ones and `ack_o` still pulses. Release → 16'hBEEF is shown without resynchronising the scan.
- Assert `rstn_i` mid-SHOW of digit 2 with a load pending → outputs return to reset values asynchronously; no `ack_o`; `disp` = 0 after release.
